// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and the parity helper.
package uart_pkg;

    localparam int UART_DATA_BITS  = 32;
    localparam int UART_FRAME_BITS = 35;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // Parity bit the transmitter appends: XOR of the data, inverted for odd parity.
    function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                        input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line; resets to the idle-high level.
module uart_rx_sync (
    input  logic CLK_Baudin,
    input  logic RstRx,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge CLK_Baudin) begin
        if (RstRx) begin
            meta     <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 32-bit UART receiver (start, 32 data LSB first, parity, stop) with valid/read handshake.
// Define UART_RX_SYNC_EN to pass the serial pin through a 2-flop synchroniser (+2 cycles).
//   state     | meaning
//   IDLE      | line idle, waiting for a 0 start bit
//   DATA      | shifting in data bits 0..31
//   PARITY    | capturing the parity bit
//   STOP      | sampling stop bit, delivering the frame
//   WAIT_HIGH | stop bit was 0 (break); wait for line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                  CLK_Baudin,
    input  logic                  RstRx,
    input  logic                  ReceivedSerialData,
    input  logic                  DataRead,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataValid,
    output logic                  DoneRx,
    output logic                  receiving,
    output logic                  ParityErr,
    output logic                  FrameErr,
    output logic                  Overrun
);

    logic                  line;
    rx_state_t             state;
    logic [5:0]            cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  parity_err_pend;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .CLK_Baudin (CLK_Baudin),
        .RstRx      (RstRx),
        .async_in   (ReceivedSerialData),
        .sync_out   (line)
    );
`else
    assign line = ReceivedSerialData;
`endif

    always_ff @(posedge CLK_Baudin) begin
        if (RstRx) begin
            state           <= IDLE;
            cnt             <= '0;
            shift           <= '0;
            parity_err_pend <= 1'b0;
            DataOut         <= '0;
            DataValid       <= 1'b0;
            DoneRx          <= 1'b0;
            receiving       <= 1'b0;
            ParityErr       <= 1'b0;
            FrameErr        <= 1'b0;
            Overrun         <= 1'b0;
        end else begin
            DoneRx <= 1'b0;
            if (DataRead) begin
                DataValid <= 1'b0;
                Overrun   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!line) begin
                        state     <= DATA;
                        cnt       <= '0;
                        receiving <= 1'b1;
                    end
                end
                DATA: begin
                    shift[cnt[4:0]] <= line;
                    if (cnt == 6'(DATA_WIDTH - 1)) begin
                        state <= PARITY;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                PARITY: begin
                    parity_err_pend <= (line != parity_bit(shift, PARITY_ODD));
                    state           <= STOP;
                end
                STOP: begin
                    // A completing frame overrides a same-cycle DataRead.
                    DataOut   <= shift;
                    ParityErr <= parity_err_pend;
                    FrameErr  <= ~line;
                    DataValid <= 1'b1;
                    DoneRx    <= 1'b1;
                    receiving <= 1'b0;
                    if (DataValid && !DataRead) begin
                        Overrun <= 1'b1;
                    end
                    state <= line ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (line) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (direct pin sampling build).
module tb_uart_rx;

    logic        CLK_Baudin = 1'b0;
    logic        RstRx;
    logic        ReceivedSerialData;
    logic        DataRead;
    logic [31:0] DataOut;
    logic        DataValid;
    logic        DoneRx;
    logic        receiving;
    logic        ParityErr;
    logic        FrameErr;
    logic        Overrun;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx dut (
        .CLK_Baudin         (CLK_Baudin),
        .RstRx              (RstRx),
        .ReceivedSerialData (ReceivedSerialData),
        .DataRead           (DataRead),
        .DataOut            (DataOut),
        .DataValid          (DataValid),
        .DoneRx             (DoneRx),
        .receiving          (receiving),
        .ParityErr          (ParityErr),
        .FrameErr           (FrameErr),
        .Overrun            (Overrun)
    );

    always #5 CLK_Baudin = ~CLK_Baudin;

    // Drive the line for one cycle; returns at the next negedge with that edge's outputs visible.
    task automatic drive_cycle(input logic b);
        ReceivedSerialData = b;
        @(negedge CLK_Baudin);
    endtask

    // Sends one frame; read_at selects the bit index during which DataRead is high (-1: none).
    task automatic send_frame(input logic [31:0] d, input logic par, input logic stop,
                              input int read_at,
                              output logic [34:0] rtrace, output logic [34:0] dtrace);
        logic b;
        for (int i = 0; i < 35; i++) begin
            if (i == 0)       b = 1'b0;
            else if (i <= 32) b = d[i-1];
            else if (i == 33) b = par;
            else              b = stop;
            DataRead = (i == read_at);
            drive_cycle(b);
            rtrace[i] = receiving;
            dtrace[i] = DoneRx;
        end
        DataRead = 1'b0;
    endtask

    task automatic read_cycle();
        DataRead = 1'b1;
        drive_cycle(1'b1);
        DataRead = 1'b0;
    endtask

    task automatic test_reset();
        RstRx = 1'b1;
        drive_cycle(1'b1);
        drive_cycle(1'b1);
        RstRx = 1'b0;
        n_cmp++;
        if ({DataOut, DataValid, DoneRx, receiving, ParityErr, FrameErr, Overrun} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h %b%b%b%b%b%b want all zero", DataOut,
                     DataValid, DoneRx, receiving, ParityErr, FrameErr, Overrun);
        end
        drive_cycle(1'b1);
    endtask

    task automatic test_good_frame();
        logic [34:0] rt, dt;
        send_frame(32'hA5A5F0F0, 1'b0, 1'b1, -1, rt, dt);
        n_cmp++;
        if (DataOut !== 32'hA5A5F0F0) begin
            n_bad++; $display("FAIL good_data: got %h want a5a5f0f0", DataOut);
        end
        n_cmp++;
        if ({DoneRx, DataValid, ParityErr, FrameErr, Overrun} !== 5'b11000) begin
            n_bad++; $display("FAIL good_flags: got %b want 11000",
                              {DoneRx, DataValid, ParityErr, FrameErr, Overrun});
        end
        n_cmp++;
        if (rt !== 35'h3_FFFF_FFFF) begin
            n_bad++; $display("FAIL good_receiving_trace: got %h want 3ffffffff", rt);
        end
        n_cmp++;
        if (dt !== 35'h4_0000_0000) begin
            n_bad++; $display("FAIL good_done_trace: got %h want 400000000", dt);
        end
        drive_cycle(1'b1);
        n_cmp++;
        if ({DoneRx, DataValid} !== 2'b01) begin
            n_bad++; $display("FAIL good_done_one_cycle: got %b want 01", {DoneRx, DataValid});
        end
        read_cycle();
        n_cmp++;
        if (DataValid !== 1'b0) begin
            n_bad++; $display("FAIL good_read_clears: got %b want 0", DataValid);
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] rt, dt;
        send_frame(32'hDEADBEEE, 1'b1, 1'b1, -1, rt, dt);
        n_cmp++;
        if (DataOut !== 32'hDEADBEEE || DoneRx !== 1'b1) begin
            n_bad++; $display("FAIL b2b_first: got %h done=%b want deadbeee done=1", DataOut, DoneRx);
        end
        send_frame(32'hAEADBEEE, 1'b0, 1'b1, 0, rt, dt);
        n_cmp++;
        if (DataOut !== 32'hAEADBEEE || ParityErr !== 1'b0) begin
            n_bad++; $display("FAIL b2b_second: got %h perr=%b want aeadbeee perr=0", DataOut, ParityErr);
        end
        n_cmp++;
        if (dt !== 35'h4_0000_0000) begin
            n_bad++; $display("FAIL b2b_spacing: got %h want 400000000", dt);
        end
        n_cmp++;
        if ({DataValid, Overrun} !== 2'b10) begin
            n_bad++; $display("FAIL b2b_no_overrun: got %b want 10", {DataValid, Overrun});
        end
        read_cycle();
    endtask

    task automatic test_parity_err();
        logic [34:0] rt, dt;
        send_frame(32'hDEADBEEE, 1'b0, 1'b1, -1, rt, dt);
        n_cmp++;
        if ({ParityErr, FrameErr, DataValid} !== 3'b101 || DataOut !== 32'hDEADBEEE) begin
            n_bad++; $display("FAIL parity_err: got perr/ferr/valid=%b data=%h want 101 deadbeee",
                              {ParityErr, FrameErr, DataValid}, DataOut);
        end
        read_cycle();
        n_cmp++;
        if (DataValid !== 1'b0) begin
            n_bad++; $display("FAIL parity_read_clears: got %b want 0", DataValid);
        end
    endtask

    task automatic test_break();
        logic [34:0] rt, dt;
        int stray;
        stray = 0;
        for (int i = 0; i < 50; i++) begin
            drive_cycle(1'b0);
            if (i == 34) begin
                n_cmp++;
                if ({DoneRx, FrameErr, ParityErr, DataValid} !== 4'b1101 || DataOut !== 32'd0) begin
                    n_bad++; $display("FAIL break_frame: got done/ferr/perr/valid=%b data=%h want 1101 0",
                                      {DoneRx, FrameErr, ParityErr, DataValid}, DataOut);
                end
            end else if (i > 34 && (receiving || DoneRx)) begin
                stray++;
            end
        end
        n_cmp++;
        if (stray !== 0) begin
            n_bad++; $display("FAIL break_no_retrigger: got %0d active cycles want 0", stray);
        end
        read_cycle();
        send_frame(32'h12345678, 1'b1, 1'b1, -1, rt, dt);
        n_cmp++;
        if (DataOut !== 32'h12345678 || {FrameErr, ParityErr, Overrun, DoneRx} !== 4'b0001) begin
            n_bad++; $display("FAIL break_recovery: got %h flags=%b want 12345678 0001",
                              DataOut, {FrameErr, ParityErr, Overrun, DoneRx});
        end
        read_cycle();
    endtask

    task automatic test_overrun();
        logic [34:0] rt, dt;
        send_frame(32'hF0F0F0F0, 1'b0, 1'b1, -1, rt, dt);
        send_frame(32'h00000001, 1'b1, 1'b1, -1, rt, dt);
        n_cmp++;
        if (DataOut !== 32'h00000001 || {Overrun, DataValid} !== 2'b11) begin
            n_bad++; $display("FAIL overrun_set: got %h ovr/valid=%b want 00000001 11",
                              DataOut, {Overrun, DataValid});
        end
        send_frame(32'h80000000, 1'b1, 1'b1, 34, rt, dt);
        n_cmp++;
        if (DataOut !== 32'h80000000 || {Overrun, DataValid, DoneRx} !== 3'b011) begin
            n_bad++; $display("FAIL overrun_simul_read: got %h ovr/valid/done=%b want 80000000 011",
                              DataOut, {Overrun, DataValid, DoneRx});
        end
        read_cycle();
    endtask

    task automatic test_reset_mid_frame();
        logic [34:0] rt, dt;
        logic [31:0] d;
        int stray;
        d = 32'h55555555;
        stray = 0;
        drive_cycle(1'b0);
        for (int i = 0; i < 10; i++) drive_cycle(d[i]);
        RstRx = 1'b1;
        drive_cycle(d[10]);
        RstRx = 1'b0;
        n_cmp++;
        if ({DataOut, DataValid, DoneRx, receiving, ParityErr, FrameErr, Overrun} !== 38'd0) begin
            n_bad++; $display("FAIL midreset_outputs: got %h %b%b%b%b%b%b want all zero", DataOut,
                              DataValid, DoneRx, receiving, ParityErr, FrameErr, Overrun);
        end
        for (int i = 0; i < 30; i++) begin
            drive_cycle(1'b1);
            if (DoneRx || receiving) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin
            n_bad++; $display("FAIL midreset_no_done: got %0d active cycles want 0", stray);
        end
        send_frame(d, 1'b0, 1'b1, -1, rt, dt);
        n_cmp++;
        if (DataOut !== 32'h55555555 || {DoneRx, DataValid, ParityErr, FrameErr} !== 4'b1100) begin
            n_bad++; $display("FAIL midreset_next_frame: got %h flags=%b want 55555555 1100",
                              DataOut, {DoneRx, DataValid, ParityErr, FrameErr});
        end
        read_cycle();
    endtask

    initial begin
        RstRx              = 1'b1;
        ReceivedSerialData = 1'b1;
        DataRead           = 1'b0;
        @(negedge CLK_Baudin);
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_parity_err();
        test_break();
        test_overrun();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
